// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
//
// Purpose:
//   Raster timing generator for a VGA-style display. A horizontal/vertical
//   pixel counter pair produces registered timing flags that line up with
//   hpos/vpos. The flags then pass through a PIPE_DELAY-stage shift register.
//   Its last stage drives the sync and colour pins. That last stage also
//   samples rgb_in.
//
// Ports:
//   clk          in   pixel clock
//   rst          in   asynchronous active-high reset
//   en           in   pixel advance enable (all state holds while low)
//   rgb_in[5:0]  in   {R[1:0],G[1:0],B[1:0]} from the pixel colour path
//   hpos/vpos    out  current pixel coordinates (10 bits each)
//   hsync/vsync  out  active-high sync flags aligned with hpos/vpos
//   visible      out  active-high display-area flag aligned with hpos/vpos
//   line_start   out  high while hpos == 0
//   frame_start  out  high while hpos == 0 and vpos == 0
//   vga_r/g/b    out  registered pin colour, blanked outside the display area
//   vga_hsync/vga_vsync out  pin syncs at SYNC_NEG polarity
//   frame_count  out  completed frames modulo 1024
//
// Configuration:
//   VGA_FRAME_COUNT_EN  define this macro to build the frame counter.
//                       When it is not defined, frame_count is tied to 0.
//
// Parameters:
//   PIPE_DELAY is legal from 1 to 4.
// -----------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int H_DISPLAY  = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_DISPLAY  = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter int PIPE_DELAY = 2,
  parameter int SYNC_NEG   = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [5:0] rgb_in,
  output logic [9:0] hpos,
  output logic [9:0] vpos,
  output logic       hsync,
  output logic       vsync,
  output logic       visible,
  output logic       line_start,
  output logic       frame_start,
  output logic [1:0] vga_r,
  output logic [1:0] vga_g,
  output logic [1:0] vga_b,
  output logic       vga_hsync,
  output logic       vga_vsync,
  output logic [9:0] frame_count
);

  localparam logic [9:0] H_LAST    = 10'(H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [9:0] V_LAST    = 10'(V_DISPLAY + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [9:0] H_VIS_END = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS_END = 10'(V_DISPLAY);
  localparam logic [9:0] HS_START  = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_END    = 10'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START  = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_END    = 10'(V_DISPLAY + V_FRONT + V_SYNC);
  localparam logic       SYNC_INACTIVE = (SYNC_NEG != 0);

  // Counters and timing flags. Flags are packed as {hsync, vsync, visible}.
  logic [9:0] h_q, h_d;
  logic [9:0] v_q, v_d;
  logic       h_wrap, v_wrap;
  logic [2:0] flags_q, flags_d;

  // Next-state logic. It does not depend on en. The register process decides
  // whether this value is loaded.
  always_comb begin
    h_wrap = (h_q == H_LAST);
    v_wrap = (v_q == V_LAST);
    h_d    = h_wrap ? 10'd0 : h_q + 10'd1;
    v_d    = v_q;
    if (h_wrap) begin
      v_d = v_wrap ? 10'd0 : v_q + 10'd1;
    end
    // The flags are decoded from the *next* coordinates. After the edge,
    // the registered flags therefore describe the same pixel as hpos/vpos.
    flags_d = {(h_d >= HS_START) && (h_d < HS_END),
               (v_d >= VS_START) && (v_d < VS_END),
               (h_d < H_VIS_END) && (v_d < V_VIS_END)};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_q     <= '0;
      v_q     <= '0;
      flags_q <= '0;
    end else if (en) begin
      h_q     <= h_d;
      v_q     <= v_d;
      flags_q <= flags_d;
    end
  end

  assign hpos        = h_q;
  assign vpos        = v_q;
  assign hsync       = flags_q[2];
  assign vsync       = flags_q[1];
  assign visible     = flags_q[0];
  assign line_start  = (h_q == 10'd0);
  assign frame_start = (h_q == 10'd0) && (v_q == 10'd0);

  // tap holds the flags that enter the final (pin) stage. It is fed through
  // PIPE_DELAY-1 intermediate stages, so the pins lag hpos by PIPE_DELAY
  // advances in total.
  logic [2:0] tap;

  generate
    if (PIPE_DELAY <= 1) begin : g_no_dly
      assign tap = flags_q;
    end else begin : g_dly
      logic [2:0] dly_q [PIPE_DELAY-1];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int k = 0; k < PIPE_DELAY - 1; k++) begin
            dly_q[k] <= '0;
          end
        end else if (en) begin
          dly_q[0] <= flags_q;
          for (int k = 1; k < PIPE_DELAY - 1; k++) begin
            dly_q[k] <= dly_q[k-1];
          end
        end
      end

      assign tap = dly_q[PIPE_DELAY-2];
    end
  endgenerate

  // Pin stage. The pins come out at the inactive level while reset is held.
  logic [5:0] rgb_q;
  logic       pin_hs_q, pin_vs_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rgb_q    <= '0;
      pin_hs_q <= SYNC_INACTIVE;
      pin_vs_q <= SYNC_INACTIVE;
    end else if (en) begin
      rgb_q    <= tap[0] ? rgb_in : 6'd0;
      pin_hs_q <= tap[2] ^ SYNC_INACTIVE;
      pin_vs_q <= tap[1] ^ SYNC_INACTIVE;
    end
  end

  assign vga_r     = rgb_q[5:4];
  assign vga_g     = rgb_q[3:2];
  assign vga_b     = rgb_q[1:0];
  assign vga_hsync = pin_hs_q;
  assign vga_vsync = pin_vs_q;

`ifdef VGA_FRAME_COUNT_EN
  logic [9:0] frame_q;

  // The frame counter steps on the edge where both counters wrap together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_q <= '0;
    end else if (en && h_wrap && v_wrap) begin
      frame_q <= frame_q + 10'd1;
    end
  end

  assign frame_count = frame_q;
`else
  assign frame_count = '0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_gen
//
// Purpose:
//   Directed testbench for vga_timing_gen. The horizontal timing keeps its
//   default 800-pixel line. The vertical timing is shortened so that whole
//   frames fit in a short run:
//     - 20 visible lines
//     - vsync on lines 23..24
//     - 30 lines in total
//
// Ports:
//   None. This is the top level of the testbench.
// -----------------------------------------------------------------------------
module tb_vga_timing_gen;

  localparam int HT  = 800;
  localparam int VD  = 20;
  localparam int VF  = 3;
  localparam int VS  = 2;
  localparam int VB  = 5;
  localparam int VT  = VD + VF + VS + VB;
  localparam int HS0 = 656;
  localparam int HS1 = 752;
  localparam int VS0 = VD + VF;
  localparam int VS1 = VD + VF + VS;
`ifdef VGA_FRAME_COUNT_EN
  localparam bit FC_ON = 1'b1;
`else
  localparam bit FC_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [5:0] rgb_in = 6'd0;
  logic [9:0] hpos, vpos, frame_count;
  logic       hsync, vsync, visible, line_start, frame_start;
  logic [1:0] vga_r, vga_g, vga_b;
  logic       vga_hsync, vga_vsync;

  vga_timing_gen #(
    .H_DISPLAY(640), .H_FRONT(16), .H_SYNC(96), .H_BACK(48),
    .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .PIPE_DELAY(2), .SYNC_NEG(1)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .rgb_in(rgb_in),
    .hpos(hpos), .vpos(vpos), .hsync(hsync), .vsync(vsync),
    .visible(visible), .line_start(line_start), .frame_start(frame_start),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_hsync(vga_hsync), .vga_vsync(vga_vsync), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model state.
  //   f0 = expected flags for the current advance.
  //   f1 = expected flags one advance back.
  //   f2 = expected flags two advances back.
  //   Flags are packed as {hs, vs, vis}.
  int         eh, ev, fc;
  logic [2:0] f0, f1, f2;
  logic       pin_hs_m, pin_vs_m;
  logic [5:0] pin_rgb_m;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h (model hpos=%0d vpos=%0d)",
               name, act, exp, eh, ev);
    end
  endtask

  task automatic model_reset();
    eh = 0; ev = 0; fc = 0;
    f0 = 3'b000; f1 = 3'b000; f2 = 3'b000;
    pin_hs_m = 1'b1; pin_vs_m = 1'b1; pin_rgb_m = 6'd0;
  endtask

  task automatic model_adv();
    if (FC_ON && eh == HT - 1 && ev == VT - 1) fc = (fc + 1) % 1024;
    if (eh == HT - 1) begin
      eh = 0;
      ev = (ev == VT - 1) ? 0 : ev + 1;
    end else begin
      eh = eh + 1;
    end
    f2 = f1;
    f1 = f0;
    f0 = {(eh >= HS0 && eh < HS1), (ev >= VS0 && ev < VS1), (eh < 640 && ev < VD)};
    pin_hs_m  = ~f2[2];
    pin_vs_m  = ~f2[1];
    pin_rgb_m = f2[0] ? rgb_in : 6'd0;
  endtask

  // Drive en for one edge. Inputs change and outputs are sampled 1 ns after
  // the active edge.
  task automatic tick(input logic en_v);
    en = en_v;
    @(posedge clk);
    #1;
    if (en_v && !rst) model_adv();
  endtask

  task automatic check_model();
    chk("hpos", 32'(hpos), 32'(eh));
    chk("vpos", 32'(vpos), 32'(ev));
    chk("hsync", 32'(hsync), 32'(f0[2]));
    chk("vsync", 32'(vsync), 32'(f0[1]));
    chk("visible", 32'(visible), 32'(f0[0]));
    chk("line_start", 32'(line_start), 32'(eh == 0));
    chk("frame_start", 32'(frame_start), 32'(eh == 0 && ev == 0));
    chk("vga_hsync", 32'(vga_hsync), 32'(pin_hs_m));
    chk("vga_vsync", 32'(vga_vsync), 32'(pin_vs_m));
    chk("vga_rgb", 32'({vga_r, vga_g, vga_b}), 32'(pin_rgb_m));
    chk("frame_count", 32'(frame_count), 32'(fc));
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_hpos"}, 32'(hpos), 32'd0);
    chk({tag, "_vpos"}, 32'(vpos), 32'd0);
    chk({tag, "_hsync"}, 32'(hsync), 32'd0);
    chk({tag, "_vsync"}, 32'(vsync), 32'd0);
    chk({tag, "_visible"}, 32'(visible), 32'd0);
    chk({tag, "_rgb"}, 32'({vga_r, vga_g, vga_b}), 32'd0);
    chk({tag, "_vga_hsync"}, 32'(vga_hsync), 32'd1);
    chk({tag, "_vga_vsync"}, 32'(vga_vsync), 32'd1);
    chk({tag, "_frame_count"}, 32'(frame_count), 32'd0);
  endtask

  typedef struct {
    logic       en;
    logic [5:0] rgb;
    int         hpos;
    int         vpos;
    logic       vis;
    logic [5:0] pins;
  } vec_t;

  vec_t tbl [7];

  initial begin
    int fs_cnt;

    // Each entry applies en and rgb_in for one edge after reset release.
    // It then gives the hpos, vpos, visible and {r,g,b} pins required after
    // that edge. The pins show pixel hpos-2 (visible from hpos 1) with the
    // rgb_in value present at the edge. With en=0 the pins must hold.
    tbl[0] = '{1'b1, 6'h3F, 1, 0, 1'b1, 6'h00};
    tbl[1] = '{1'b1, 6'h3F, 2, 0, 1'b1, 6'h00};
    tbl[2] = '{1'b1, 6'h3F, 3, 0, 1'b1, 6'h3F};
    tbl[3] = '{1'b0, 6'h00, 3, 0, 1'b1, 6'h3F};
    tbl[4] = '{1'b1, 6'h24, 4, 0, 1'b1, 6'h24};
    tbl[5] = '{1'b0, 6'h3F, 4, 0, 1'b1, 6'h24};
    tbl[6] = '{1'b1, 6'h09, 5, 0, 1'b1, 6'h09};

    model_reset();

    // Reset held with en low, and then with en high.
    tick(1'b0);
    tick(1'b0);
    check_reset_values("rst_idle");
    tick(1'b1);
    tick(1'b1);
    check_model();

    rst = 1'b0;
    for (int i = 0; i < 7; i++) begin
      rgb_in = tbl[i].rgb;
      tick(tbl[i].en);
      chk("tbl_hpos", 32'(hpos), 32'(tbl[i].hpos));
      chk("tbl_vpos", 32'(vpos), 32'(tbl[i].vpos));
      chk("tbl_visible", 32'(visible), 32'(tbl[i].vis));
      chk("tbl_pins", 32'({vga_r, vga_g, vga_b}), 32'(tbl[i].pins));
      check_model();
    end

    // Run one full frame plus the wrap, with a constant white pixel input.
    rgb_in = 6'h3F;
    fs_cnt = 0;
    for (int n = 0; n < HT * VT; n++) begin
      tick(1'b1);
      check_model();
      if (frame_start) fs_cnt++;
      if (eh == 0 && ev == 0) begin
        chk("wrap_hpos", 32'(hpos), 32'd0);
        chk("wrap_vpos", 32'(vpos), 32'd0);
        chk("wrap_frame_start", 32'(frame_start), 32'd1);
      end
    end
    chk("frame_start_pulses", 32'(fs_cnt), 32'd1);
    chk("frame_count_after_frame", 32'(frame_count), FC_ON ? 32'd1 : 32'd0);

    // Toggle en every cycle. The outputs must hold on each en=0 cycle.
    for (int n = 0; n < 20; n++) begin
      tick(n[0] ? 1'b0 : 1'b1);
      check_model();
    end

    // Advance to hpos=300, vpos=10. Then pulse reset between clock edges.
    for (int n = 0; n < HT * VT && !(eh == 300 && ev == 10); n++) begin
      tick(1'b1);
      check_model();
    end
    chk("pre_rst_hpos", 32'(hpos), 32'd300);
    chk("pre_rst_vpos", 32'(vpos), 32'd10);
    rst = 1'b1;
    #1;
    check_reset_values("async_rst");
    model_reset();
    tick(1'b1);
    check_model();
    rst = 1'b0;
    tick(1'b1);
    chk("post_rst_hpos", 32'(hpos), 32'd1);
    chk("post_rst_vpos", 32'(vpos), 32'd0);
    check_model();
    for (int n = 0; n < 2 * HT; n++) begin
      tick(1'b1);
      check_model();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter H_DISPLAY, 640, visible pixels per line.
REQ-002 SHALL have parameter H_FRONT, 16, horizontal front porch in pixels.
REQ-003 SHALL have parameter H_SYNC, 96, horizontal sync width in pixels.
REQ-004 SHALL have parameter H_BACK, 48, horizontal back porch; H_TOTAL = sum of the four H_* values (800).
REQ-005 SHALL have parameters V_DISPLAY 480, V_FRONT 10, V_SYNC 2 and V_BACK 33, vertical equivalents of the H_* parameters; V_TOTAL = 525.
REQ-006 SHALL have parameter PIPE_DELAY, 2, pixel-path latency in cycles from hpos/vpos to the pin outputs; legal range 1..4.
REQ-007 SHALL have parameter SYNC_NEG, 1, pin sync polarity: 1 = active-low.
REQ-008 Port clk, input, 1, pixel clock; one clock only.
REQ-009 Port rst, input, 1, asynchronous active-high reset.
REQ-010 Port en, input, 1, pixel advance enable.
REQ-011 Ports hpos and vpos, output, 10 each, current pixel coordinates.
REQ-012 Ports hsync, vsync and visible, output, 1 each, active-high timing flags aligned with hpos/vpos.
REQ-013 Ports line_start and frame_start, output, 1 each, single-pixel pulses.
REQ-014 Port rgb_in, input, 6, {R[1:0],G[1:0],B[1:0]} from the pixel color path.
REQ-015 Ports vga_r, vga_g and vga_b, output, 2 each, registered pin color.
REQ-016 Ports vga_hsync and vga_vsync, output, 1 each, pin syncs at SYNC_NEG polarity.
REQ-017 Port frame_count, output, 10, frames completed modulo 1024.

Function
REQ-018 All state SHALL advance only on a clk edge with en=1; with en=0, counters, pipeline and outputs hold.
REQ-019 hpos SHALL increment by 1 per advance and wrap from H_TOTAL-1 to 0; vpos SHALL increment only on that wrap.
REQ-020 vpos SHALL wrap from V_TOTAL-1 to 0; when hpos=H_TOTAL-1 and vpos=V_TOTAL-1, both SHALL wrap on the same edge.
REQ-021 hsync, vsync and visible SHALL be registered and valid in the same cycle as the hpos/vpos they describe; they are never combinational from the next-state logic.
REQ-022 hsync SHALL be 1 iff H_DISPLAY+H_FRONT <= hpos < H_DISPLAY+H_FRONT+H_SYNC; vsync is the vertical equivalent on vpos.
REQ-023 visible SHALL be 1 iff hpos < H_DISPLAY and vpos < V_DISPLAY.
REQ-024 line_start SHALL be 1 iff hpos=0; frame_start SHALL be 1 iff hpos=0 and vpos=0.
REQ-025 hsync, vsync and visible SHALL pass through a PIPE_DELAY-stage shift register; the last stage drives the pin outputs.
REQ-026 rgb_in SHALL be sampled in the last pipeline stage, so the color for the pixel at cycle t is sampled at cycle t+PIPE_DELAY-1 and appears on the pins at cycle t+PIPE_DELAY.
REQ-027 vga_r/g/b SHALL be forced to 0 whenever the delayed visible flag is 0, regardless of rgb_in.
REQ-028 vga_hsync SHALL equal delayed hsync XOR SYNC_NEG; vga_vsync follows the same rule.

Reset
REQ-029 While rst=1, regardless of en: hpos=0, vpos=0, and all pipeline stages clear.
REQ-030 While rst=1: hsync=0, vsync=0, visible=0 and vga_r/g/b=0.
REQ-031 While rst=1: vga_hsync=vga_vsync=SYNC_NEG (inactive level) and frame_count=0.
REQ-032 Assertion mid-frame SHALL take effect immediately, without waiting for a clock edge.
REQ-033 After deassertion, the first advance SHALL move to hpos=1, vpos=0.

Configuration
REQ-034 Macro VGA_FRAME_COUNT_EN defined: frame_count SHALL increment by 1, wrapping at 1023 to 0, on the edge where both counters wrap.
REQ-035 Macro VGA_FRAME_COUNT_EN undefined: frame_count SHALL be constant 0 and no counter register is synthesized.

Verification
REQ-036 Reset release, en=1 for 800 cycles -> hpos runs 0..799 then 0, vpos steps to 1, hsync high for exactly hpos 656..751.
REQ-037 Full frame, 420000 cycles -> vsync high for vpos 490..491 only; frame_start pulses once; frame_count=1 (macro on) or 0 (macro off).
REQ-038 rgb_in=6'b111111 constant, PIPE_DELAY=2 -> pins nonzero only from 2 cycles after visible rises until 2 cycles after it falls; vga_hsync low exactly 2 cycles after hsync rises.
REQ-039 en toggled 1/0 every cycle -> hpos advances once per 2 clocks; pipeline outputs hold during en=0 cycles.
REQ-040 rst pulsed at hpos=300, vpos=200 -> all outputs take reset values before the next edge; counting restarts at hpos=0, vpos=0.
REQ-041 Run to hpos=799, vpos=524 -> next advance gives hpos=0, vpos=0 and frame_start=1 simultaneously.
